octant_ray_walker: RTL and testbench

Streams map cells along a ray in the full plane from an octant-reduced Bresenham description. An upstream block folds the beam angle into the first octant and produces the major/minor cell deltas plus the `flip_y`, `flip_x` and `flip_identity` flags. This block runs Bresenham in that octant and unfolds every step back into world-oriented map coordinates. Its output is a one-cell-per-cycle valid/ready stream that feeds the occupancy-grid update logic.

---
 rtl/bresenham_pkg.sv | 19 +
 rtl/octant_unfold.sv | 43 ++++
 rtl/octant_ray_walker.sv | 208 ++++++++++++++++++++
 tb/tb_octant_ray_walker.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bresenham_pkg.sv
// Shared definitions for the reduced-octant Bresenham ray walker.
//   walk_state_t     : walker FSM states (idle, emitting cells, done pulse)
//   COORD_W_DEFAULT  : default signed map-coordinate width
//   LEN_W_DEFAULT    : default unsigned ray-delta width
//   PI_Q14_18        : fixed-point PI shared with the angle reduction stage
package bresenham_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } walk_state_t;

    localparam int COORD_W_DEFAULT = 16;
    localparam int LEN_W_DEFAULT   = 16;

    localparam logic [31:0] PI_Q14_18 = 32'h000C_90FD;

endpackage

// File: rtl/octant_unfold.sv
// Maps a reduced-octant step (u along the major axis, v along the minor axis)
// back into world-oriented signed offsets (p, q).
//   u_i, v_i         : unsigned reduced coordinates
//   flip_identity_i  : axes were swapped by the reduction
//   flip_x_i         : world x was mirrored
//   flip_y_i         : world y was mirrored
//   p_o, q_o         : signed world offsets (x, y), modulo 2^COORD_W
module octant_unfold
    import bresenham_pkg::*;
#(
    parameter int LEN_W   = LEN_W_DEFAULT,
    parameter int COORD_W = COORD_W_DEFAULT
) (
    input  logic [LEN_W-1:0]          u_i,
    input  logic [LEN_W-1:0]          v_i,
    input  logic                      flip_y_i,
    input  logic                      flip_x_i,
    input  logic                      flip_identity_i,
    output logic signed [COORD_W-1:0] p_o,
    output logic signed [COORD_W-1:0] q_o
);

    logic signed [COORD_W-1:0] u_s;
    logic signed [COORD_W-1:0] v_s;
    logic signed [COORD_W-1:0] p_sw;
    logic signed [COORD_W-1:0] q_sw;

    // Undo the reduction in reverse order: axis swap first, then mirrors.
    always_comb begin
        u_s = COORD_W'(u_i);
        v_s = COORD_W'(v_i);
        if (flip_identity_i) begin
            p_sw = v_s;
            q_sw = u_s;
        end else begin
            p_sw = u_s;
            q_sw = v_s;
        end
        p_o = flip_x_i ? -p_sw : p_sw;
        q_o = flip_y_i ? -q_sw : q_sw;
    end

endmodule

// File: rtl/octant_ray_walker.sv
// Walks a Bresenham line in the reduced octant and streams the unfolded
// world cells, one per cycle, on a valid/ready interface.
//   clk, reset            : clock, synchronous active-high reset
//   start                 : begin a ray (taken only while busy=0)
//   dx, dy                : reduced major/minor deltas (dy clamped to dx)
//   flip_y/x/identity     : octant flags from the reduction stage
//   origin_x, origin_y    : signed start cell
//   busy                  : ray in progress (through the done cycle)
//   cell_valid/ready      : output handshake
//   cell_x, cell_y        : world cell (wrapping sums)
//   cell_last             : final cell of the ray
//   done                  : one-cycle pulse after the last handshake
module octant_ray_walker
    import bresenham_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEFAULT,
    parameter int LEN_W   = LEN_W_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [LEN_W-1:0]          dx,
    input  logic [LEN_W-1:0]          dy,
    input  logic                      flip_y,
    input  logic                      flip_x,
    input  logic                      flip_identity,
    input  logic signed [COORD_W-1:0] origin_x,
    input  logic signed [COORD_W-1:0] origin_y,
    output logic                      busy,
    output logic                      cell_valid,
    input  logic                      cell_ready,
    output logic signed [COORD_W-1:0] cell_x,
    output logic signed [COORD_W-1:0] cell_y,
    output logic                      cell_last,
    output logic                      done
);

    localparam int E_W = LEN_W + 2;

    walk_state_t               state_q, state_d;
    logic [LEN_W-1:0]          dx_q, dx_d, dy_q, dy_d;
    logic [LEN_W-1:0]          u_q, u_d, v_q, v_d;
    logic signed [E_W-1:0]     e_q, e_d;
    logic                      flip_y_q, flip_y_d, flip_x_q, flip_x_d;
    logic                      flip_id_q, flip_id_d;
    logic signed [COORD_W-1:0] org_x_q, org_x_d, org_y_q, org_y_d;
    logic signed [COORD_W-1:0] cell_x_q, cell_x_d, cell_y_q, cell_y_d;
    logic                      cell_valid_q, cell_valid_d;
    logic                      cell_last_q, cell_last_d;
    logic                      busy_q, busy_d, done_q, done_d;

    logic [LEN_W-1:0]          dy_clamped;
    logic signed [E_W-1:0]     e_init;
    logic signed [E_W-1:0]     dx_ext, dy_ext;
    logic [LEN_W-1:0]          step_u, step_v;
    logic signed [E_W-1:0]     step_e;
    logic signed [COORD_W-1:0] step_p, step_q;
    logic                      handshake;

    assign handshake = cell_valid_q && cell_ready;

    // Start-time setup: clamp dy so an over-steep request degrades to 45 degrees.
    always_comb begin
        dy_clamped = (dy > dx) ? dx : dy;
        e_init     = signed'({1'b0, dy_clamped, 1'b0}) - signed'({2'b00, dx});
    end

    // One Bresenham step from the currently presented cell to the next one.
    always_comb begin
        dx_ext = signed'({2'b00, dx_q});
        dy_ext = signed'({2'b00, dy_q});
        step_u = u_q + LEN_W'(1);
        if (!e_q[E_W-1] && (e_q != '0)) begin
            step_v = v_q + LEN_W'(1);
            step_e = e_q + ((dy_ext - dx_ext) <<< 1);
        end else begin
            step_v = v_q;
            step_e = e_q + (dy_ext <<< 1);
        end
    end

    octant_unfold #(
        .LEN_W   (LEN_W),
        .COORD_W (COORD_W)
    ) u_unfold (
        .u_i             (step_u),
        .v_i             (step_v),
        .flip_y_i        (flip_y_q),
        .flip_x_i        (flip_x_q),
        .flip_identity_i (flip_id_q),
        .p_o             (step_p),
        .q_o             (step_q)
    );

    always_comb begin
        state_d      = state_q;
        dx_d         = dx_q;
        dy_d         = dy_q;
        u_d          = u_q;
        v_d          = v_q;
        e_d          = e_q;
        flip_y_d     = flip_y_q;
        flip_x_d     = flip_x_q;
        flip_id_d    = flip_id_q;
        org_x_d      = org_x_q;
        org_y_d      = org_y_q;
        cell_x_d     = cell_x_q;
        cell_y_d     = cell_y_q;
        cell_valid_d = cell_valid_q;
        cell_last_d  = cell_last_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_RUN;
                    dx_d         = dx;
                    dy_d         = dy_clamped;
                    u_d          = '0;
                    v_d          = '0;
                    e_d          = e_init;
                    flip_y_d     = flip_y;
                    flip_x_d     = flip_x;
                    flip_id_d    = flip_identity;
                    org_x_d      = origin_x;
                    org_y_d      = origin_y;
                    // (u,v) = (0,0) unfolds to the origin under every flag set.
                    cell_x_d     = origin_x;
                    cell_y_d     = origin_y;
                    cell_valid_d = 1'b1;
                    cell_last_d  = (dx == '0);
                end
            end
            ST_RUN: begin
                if (handshake) begin
                    if (cell_last_q) begin
                        state_d      = ST_FIN;
                        cell_valid_d = 1'b0;
                        cell_last_d  = 1'b0;
                    end else begin
                        u_d         = step_u;
                        v_d         = step_v;
                        e_d         = step_e;
                        cell_x_d    = org_x_q + step_p;
                        cell_y_d    = org_y_q + step_q;
                        cell_last_d = (step_u == dx_q);
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_FIN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            dx_q         <= '0;
            dy_q         <= '0;
            u_q          <= '0;
            v_q          <= '0;
            e_q          <= '0;
            flip_y_q     <= 1'b0;
            flip_x_q     <= 1'b0;
            flip_id_q    <= 1'b0;
            org_x_q      <= '0;
            org_y_q      <= '0;
            cell_x_q     <= '0;
            cell_y_q     <= '0;
            cell_valid_q <= 1'b0;
            cell_last_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            dx_q         <= dx_d;
            dy_q         <= dy_d;
            u_q          <= u_d;
            v_q          <= v_d;
            e_q          <= e_d;
            flip_y_q     <= flip_y_d;
            flip_x_q     <= flip_x_d;
            flip_id_q    <= flip_id_d;
            org_x_q      <= org_x_d;
            org_y_q      <= org_y_d;
            cell_x_q     <= cell_x_d;
            cell_y_q     <= cell_y_d;
            cell_valid_q <= cell_valid_d;
            cell_last_q  <= cell_last_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign cell_valid = cell_valid_q;
    assign cell_last  = cell_last_q;
    assign cell_x     = cell_x_q;
    assign cell_y     = cell_y_q;

endmodule

// File: tb/tb_octant_ray_walker.sv
// Self-checking bench for octant_ray_walker: a table of rays with
// hand-derived expected cells feeds a scoreboard queue; a negedge monitor
// pops and compares each handshaked cell, checks stall stability and the
// done pulse timing. Reset and mid-ray start cases are hand sequenced.
`timescale 1ns/1ps
module tb_octant_ray_walker;

    localparam int COORD_W = 16;
    localparam int LEN_W   = 16;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      start;
    logic [LEN_W-1:0]          dx, dy;
    logic                      flip_y, flip_x, flip_identity;
    logic signed [COORD_W-1:0] origin_x, origin_y;
    logic                      busy, cell_valid, cell_ready, cell_last, done;
    logic signed [COORD_W-1:0] cell_x, cell_y;

    always #5 clk = ~clk;

    octant_ray_walker #(
        .COORD_W (COORD_W),
        .LEN_W   (LEN_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .dx            (dx),
        .dy            (dy),
        .flip_y        (flip_y),
        .flip_x        (flip_x),
        .flip_identity (flip_identity),
        .origin_x      (origin_x),
        .origin_y      (origin_y),
        .busy          (busy),
        .cell_valid    (cell_valid),
        .cell_ready    (cell_ready),
        .cell_x        (cell_x),
        .cell_y        (cell_y),
        .cell_last     (cell_last),
        .done          (done)
    );

    typedef struct {
        int               dx;
        int               dy;
        bit               fy;
        bit               fx;
        bit               fi;
        int               ox;
        int               oy;
        int               n;
        logic [7:0][15:0] cx;
        logic [7:0][15:0] cy;
    } ray_t;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic        last;
    } exp_t;

    ray_t rays[8];
    int   n_rays = 0;
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    task automatic add_ray(input int rdx, input int rdy, input bit fy, input bit fx,
                           input bit fi, input int ox, input int oy);
        rays[n_rays].dx = rdx;
        rays[n_rays].dy = rdy;
        rays[n_rays].fy = fy;
        rays[n_rays].fx = fx;
        rays[n_rays].fi = fi;
        rays[n_rays].ox = ox;
        rays[n_rays].oy = oy;
        rays[n_rays].n  = 0;
        rays[n_rays].cx = '0;
        rays[n_rays].cy = '0;
        n_rays++;
    endtask

    task automatic add_cell(input int x, input int y);
        int r;
        r = n_rays - 1;
        rays[r].cx[rays[r].n] = 16'(x);
        rays[r].cy[rays[r].n] = 16'(y);
        rays[r].n++;
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic drive_ray(input int i);
        dx            = 16'(rays[i].dx);
        dy            = 16'(rays[i].dy);
        flip_y        = rays[i].fy;
        flip_x        = rays[i].fx;
        flip_identity = rays[i].fi;
        origin_x      = 16'(rays[i].ox);
        origin_y      = 16'(rays[i].oy);
        start         = 1'b1;
    endtask

    task automatic push_expected(input int i);
        exp_t e;
        for (int k = 0; k < rays[i].n; k++) begin
            e.x    = rays[i].cx[k];
            e.y    = rays[i].cy[k];
            e.last = (k == rays[i].n - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy still 1 after %0d cycles", k);
        end
    endtask

    // mode 0: ready held high; mode 1: ready pattern 1,0,0 repeating.
    // mid: drive an extra start while the ray is in flight (must be ignored).
    task automatic run_ray(input int i, input int mode, input bit mid);
        int cyc;
        bit got_done;
        wait_idle();
        push_expected(i);
        drive_ray(i);
        cell_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk($sformatf("ray%0d_first_busy", i), int'(busy), 1);
        chk($sformatf("ray%0d_first_valid", i), int'(cell_valid), 1);
        cyc      = 0;
        got_done = 1'b0;
        while (!got_done && cyc < 200) begin
            cell_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            if (mid && cyc == 2) begin
                chk($sformatf("ray%0d_busy_mid", i), int'(busy), 1);
                dx       = 16'd7;
                origin_x = 16'sd999;
                start    = 1'b1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) got_done = 1'b1;
            cyc++;
        end
        if (!got_done) begin
            checks++;
            errors++;
            $display("FAIL ray%0d_done_timeout: no done within %0d cycles", i, cyc);
        end else begin
            chk($sformatf("ray%0d_done_valid", i), int'(cell_valid), 0);
            chk($sformatf("ray%0d_done_busy", i), int'(busy), 1);
            chk($sformatf("ray%0d_queue_empty", i), exp_q.size(), 0);
            @(posedge clk);
            #1;
            chk($sformatf("ray%0d_after_busy", i), int'(busy), 0);
            chk($sformatf("ray%0d_after_done", i), int'(done), 0);
        end
        exp_q.delete();
    endtask

    // Scoreboard monitor: samples on the falling edge, i.e. the values the
    // next rising edge will see.
    initial begin
        exp_t        e;
        logic [15:0] px, py;
        logic        pl;
        bit          pstall;
        bit          dexp;
        px     = '0;
        py     = '0;
        pl     = 1'b0;
        pstall = 1'b0;
        dexp   = 1'b0;
        forever begin
            @(negedge clk);
            if (!mon_en || reset) begin
                pstall = 1'b0;
                dexp   = 1'b0;
            end else begin
                if (pstall) begin
                    checks++;
                    if (!cell_valid || cell_x !== px || cell_y !== py || cell_last !== pl) begin
                        errors++;
                        $display("FAIL stall_hold: valid=%0b x=%0d y=%0d last=%0b, expected valid=1 x=%0d y=%0d last=%0b",
                                 cell_valid, cell_x, cell_y, cell_last,
                                 $signed(px), $signed(py), pl);
                    end
                end
                if (dexp || done) begin
                    checks++;
                    if (done !== dexp) begin
                        errors++;
                        $display("FAIL done_timing: done=%0b, expected %0b", done, dexp);
                    end
                end
                dexp = 1'b0;
                if (cell_valid && cell_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_cell: x=%0d y=%0d last=%0b with empty scoreboard",
                                 cell_x, cell_y, cell_last);
                    end else begin
                        e = exp_q.pop_front();
                        if (cell_x !== e.x || cell_y !== e.y || cell_last !== e.last) begin
                            errors++;
                            $display("FAIL cell: got x=%0d y=%0d last=%0b, expected x=%0d y=%0d last=%0b",
                                     cell_x, cell_y, cell_last,
                                     $signed(e.x), $signed(e.y), e.last);
                        end else begin
                            $display("cell x=%0d y=%0d last=%0b ok", cell_x, cell_y, cell_last);
                        end
                    end
                    dexp = cell_last;
                end
                pstall = cell_valid && !cell_ready;
                px     = cell_x;
                py     = cell_y;
                pl     = cell_last;
            end
        end
    end

    initial begin
        reset         = 1'b1;
        start         = 1'b0;
        dx            = '0;
        dy            = '0;
        flip_y        = 1'b0;
        flip_x        = 1'b0;
        flip_identity = 1'b0;
        origin_x      = '0;
        origin_y      = '0;
        cell_ready    = 1'b0;

        // 0: basic ray
        add_ray(4, 2, 0, 0, 0, 10, 10);
        add_cell(10, 10); add_cell(11, 10); add_cell(12, 11); add_cell(13, 11); add_cell(14, 12);
        // 1: all flags set
        add_ray(4, 2, 1, 1, 1, 10, 10);
        add_cell(10, 10); add_cell(10, 9); add_cell(9, 8); add_cell(9, 7); add_cell(8, 6);
        // 2: zero-length ray
        add_ray(0, 0, 0, 0, 0, -3, 7);
        add_cell(-3, 7);
        // 3: coordinate wrap
        add_ray(2, 0, 0, 0, 0, 32767, 0);
        add_cell(32767, 0); add_cell(-32768, 0); add_cell(-32767, 0);
        // 4: dy > dx clamps to a 45-degree line
        add_ray(3, 5, 0, 0, 0, 0, 0);
        add_cell(0, 0); add_cell(1, 1); add_cell(2, 2); add_cell(3, 3);
        // 5: dx=3 dy=1, mirrored x
        add_ray(3, 1, 0, 1, 0, 5, -5);
        add_cell(5, -5); add_cell(4, -5); add_cell(3, -4); add_cell(2, -4);
        // 6: dx=3 dy=1, axes swapped
        add_ray(3, 1, 0, 0, 1, 0, 0);
        add_cell(0, 0); add_cell(0, 1); add_cell(1, 2); add_cell(1, 3);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_valid", int'(cell_valid), 0);
        chk("reset_last", int'(cell_last), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_x", int'(cell_x), 0);
        chk("reset_y", int'(cell_y), 0);
        reset  = 1'b0;
        mon_en = 1'b1;

        for (int i = 0; i < 5; i++) run_ray(i, 0, 1'b0);
        run_ray(5, 1, 1'b1);
        run_ray(6, 1, 1'b0);

        // Reset while the third cell is presented.
        wait_idle();
        mon_en = 1'b0;
        drive_ray(0);
        cell_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("pre_reset_x", int'(cell_x), 12);
        chk("pre_reset_y", int'(cell_y), 11);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midreset_busy", int'(busy), 0);
        chk("midreset_valid", int'(cell_valid), 0);
        chk("midreset_last", int'(cell_last), 0);
        chk("midreset_done", int'(done), 0);
        chk("midreset_x", int'(cell_x), 0);
        chk("midreset_y", int'(cell_y), 0);
        reset = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("post_reset_done", int'(done), 0);
            chk("post_reset_valid", int'(cell_valid), 0);
        end
        exp_q.delete();
        mon_en = 1'b1;
        run_ray(0, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
